cpu_controller_fsm: RTL and testbench
=====================================

// Module: cpu_controller_fsm
// PURPOSE
// - Control state machine for the lab6 CPU: consumes opcode/op from the instruction decoder and sequences
//   datapath controls for one instruction per start pulse; w tells the testbench/top when the CPU is idle.
// - Sits between the decoder (upstream) and the datapath (downstream, driving register file, A/B/C, status).
// PARAMETERS
// - (none): state, opcode and select encodings are fixed constants in cpu_pkg
// PORTS
// - clk     in   1  rising-edge clock; only clock in the block
// - reset   in   1  synchronous, active-high; forces WAIT on the next rising edge
// - s       in   1  start; sampled only in WAIT
// - opcode  in   3  from decoder: 3'b110 MOV, 3'b101 ALU
// - op      in   2  from decoder: MOV 10=imm,00=reg; ALU 00=ADD,01=CMP,10=AND,11=MVN
// - nsel    out  3  one-hot register select: 001=Rm, 010=Rd, 100=Rn, 000=none
// - vsel    out  2  writeback source: 00=C, 10=sximm8 (01, 11 reserved, never driven)
// - loada   out  1  load A register
// - loadb   out  1  load B register
// - asel    out  1  1 = feed 0 into ALU A input (MOV reg, MVN)
// - bsel    out  1  1 = feed sximm5 into ALU B; always 0 in this ISA subset
// - loadc   out  1  load C register
// - loads   out  1  load status flags N/V/Z
// - write   out  1  register-file write enable
// - w       out  1  1 while in WAIT (idle, ready for s)
// - illegal out  1  one-cycle pulse when DECODE sees an undefined opcode/op
// BEHAVIOUR
// - Moore FSM, registered state; all outputs are decoded from state only, plus opcode/op where noted.
// - Reset: on the edge with reset=1, state becomes WAIT. Outputs then read w=1, all others 0 (nsel=000, vsel=00).
//   Reset wins over s and over any in-flight instruction. A partial instruction is abandoned, with no write issued.
// - WAIT: w=1; s=1 -> DECODE, else stay. If s is held high, a new instruction launches every time WAIT is reached.
// - DECODE: all strobes 0. Next state:
//   - MOV/10 -> WRITE_IMM
//   - MOV/00 or ALU/11 -> GET_B
//   - ALU/00, ALU/01 or ALU/10 -> GET_A
//   - anything else -> WAIT, with illegal=1 for this cycle
// - GET_A: nsel=100 (Rn), loada=1 -> GET_B.
// - GET_B: nsel=001 (Rm), loadb=1 -> EXEC.
// - EXEC: bsel=0; asel=1 for MOV/00 and ALU/11, else 0. Next state:
//   - CMP: loads=1, loadc=0 -> WAIT
//   - all others: loadc=1, loads=1 for ALU ops (0 for MOV) -> WRITE_REG
// - WRITE_REG: nsel=010 (Rd), vsel=00, write=1 -> WAIT.
// - WRITE_IMM: nsel=100 (Rn), vsel=10, write=1 -> WAIT.
// - Latency, counted in rising edges from the edge sampling s=1 to the edge re-entering WAIT:
//   MOV imm=3; MOV reg and MVN=5; CMP=5 (DECODE,GET_A,GET_B,EXEC,WAIT); ADD/AND=6.
// - s is ignored outside WAIT.
// - opcode/op must be stable from the s edge until WAIT is re-entered; IR loads only while w=1.
// - Exactly one write pulse per non-CMP instruction; none for CMP or illegal.
// - No combinational path from s to any output.
// - Unreachable state encodings recover to WAIT on the next edge.
// STRUCTURE
// - cpu_pkg holds shared definitions:
//   - state_t enum: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM
//   - OPC_MOV/OPC_ALU constants and op constants (OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOVI, OP_MOVR)
//   - NSEL_RN/RD/RM/NONE and VSEL_C/VSEL_IMM8 constants
// - Single module: state register always_ff, next-state always_comb, output always_comb. No sub-module.
// TESTING
// - Reset: reset=1 for 1 edge from any state -> w=1, nsel=000, write=0, loada=loadb=loadc=loads=0.
// - MOV R0,#7 (opcode 110, op 10), s=1 for 1 cycle:
//   - cycle 2: write=1, nsel=100, vsel=10
//   - w=1 again 3 edges after s
// - ADD (101/00):
//   - state trace DECODE,GET_A(loada,nsel=100),GET_B(loadb,nsel=001),EXEC(loadc,loads,asel=0),
//     WRITE_REG(write,nsel=010,vsel=00)
//   - w returns after 6 edges
// - CMP (101/01): EXEC asserts loads=1, loadc=0; no write pulse ever; w after 5 edges.
// - MVN and MOV R1,R2,LSL (101/11, 110/00): no GET_A; EXEC asel=1; MVN loads=1, MOV loads=0; write once.
// - Boundary cases:
//   - s toggled mid-ADD is ignored
//   - reset at GET_B -> WAIT next edge, no write
//   - opcode 3'b000 -> illegal=1 for one cycle, back to WAIT
//   - s held high -> back-to-back instructions

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the lab6 CPU controller: FSM states, decoder
// opcode/op values and datapath select constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    GET_A     = 3'd2,
    GET_B     = 3'd3,
    EXEC      = 3'd4,
    WRITE_REG = 3'd5,
    WRITE_IMM = 3'd6
  } state_t;

  // Decoder opcodes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // ALU op field
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  // MOV op field
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;

  // One-hot register-file select
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  // Writeback source select
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // MOV accepts only the immediate and register forms; every ALU op is defined.
  function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_ALU) ||
           (opcode == OPC_MOV && (op == OP_MOVI || op == OP_MOVR));
  endfunction

endpackage

// File: rtl/cpu_controller_fsm_if.sv
// Decoder-to-controller inputs and controller-to-datapath strobes.
// master = surrounding CPU top / decoder side, slave = the controller FSM.
interface cpu_controller_fsm_if;

  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;

  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       w;
  logic       illegal;

  modport master (
    output s, opcode, op,
    input  nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, w, illegal
  );

  modport slave (
    input  s, opcode, op,
    output nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, w, illegal
  );

endinterface

// File: rtl/cpu_controller_fsm.sv
// Moore control FSM for the lab6 CPU: sequences one MOV/ALU instruction per
// start pulse and drives register-file, A/B/C and status strobes.
module cpu_controller_fsm
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cpu_controller_fsm_if.slave bus
);

  state_t state;
  state_t state_next;

  logic is_alu;
  logic is_movr;
  logic is_cmp;

  assign is_alu  = (bus.opcode == OPC_ALU);
  assign is_movr = (bus.opcode == OPC_MOV) && (bus.op == OP_MOVR);
  assign is_cmp  = is_alu && (bus.op == OP_CMP);

  // State register: synchronous reset returns to WAIT, abandoning any instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start accepted only in WAIT; decode routes by opcode/op.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = WAIT;
    unique case (state)
      WAIT:      state_next = bus.s ? DECODE : WAIT;
      DECODE: begin
        if (!is_legal(bus.opcode, bus.op))           state_next = WAIT;
        else if (bus.opcode == OPC_MOV && bus.op == OP_MOVI) state_next = WRITE_IMM;
        else if (is_movr || (is_alu && bus.op == OP_MVN))    state_next = GET_B;
        else                                          state_next = GET_A;
      end
      GET_A:     state_next = GET_B;
      GET_B:     state_next = EXEC;
      EXEC:      state_next = is_cmp ? WAIT : WRITE_REG;
      WRITE_REG: state_next = WAIT;
      WRITE_IMM: state_next = WAIT;
      default:   state_next = WAIT;  // unused encoding recovers to idle
    endcase
  end

  // Output decode: strobes from state, with opcode/op qualifying EXEC and DECODE.
  always_comb begin
    bus.nsel    = NSEL_NONE;
    bus.vsel    = VSEL_C;
    bus.loada   = 1'b0;
    bus.loadb   = 1'b0;
    bus.asel    = 1'b0;
    bus.bsel    = 1'b0;
    bus.loadc   = 1'b0;
    bus.loads   = 1'b0;
    bus.write   = 1'b0;
    bus.w       = 1'b0;
    bus.illegal = 1'b0;
    unique case (state)
      WAIT:   bus.w = 1'b1;
      DECODE: bus.illegal = !is_legal(bus.opcode, bus.op);
      GET_A: begin
        bus.nsel  = NSEL_RN;
        bus.loada = 1'b1;
      end
      GET_B: begin
        bus.nsel  = NSEL_RM;
        bus.loadb = 1'b1;
      end
      EXEC: begin
        // MOV reg and MVN pass B through, so the A operand is forced to zero.
        bus.asel  = is_movr || (is_alu && bus.op == OP_MVN);
        bus.loads = is_alu;
        bus.loadc = !is_cmp;
      end
      WRITE_REG: begin
        bus.nsel  = NSEL_RD;
        bus.vsel  = VSEL_C;
        bus.write = 1'b1;
      end
      WRITE_IMM: begin
        bus.nsel  = NSEL_RN;
        bus.vsel  = VSEL_IMM8;
        bus.write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Directed plus randomized bench for cpu_controller_fsm. Each instruction is
// expanded into its expected per-cycle control trace from the ISA rules,
// then compared against the DUT one rising edge at a time.
module tb_cpu_controller_fsm;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       w;
    logic       illegal;
  } ctl_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  ctl_t exp_q[$];

  cpu_controller_fsm_if bus ();

  cpu_controller_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t observe();
    ctl_t c;
    c.nsel    = bus.nsel;
    c.vsel    = bus.vsel;
    c.loada   = bus.loada;
    c.loadb   = bus.loadb;
    c.asel    = bus.asel;
    c.bsel    = bus.bsel;
    c.loadc   = bus.loadc;
    c.loads   = bus.loads;
    c.write   = bus.write;
    c.w       = bus.w;
    c.illegal = bus.illegal;
    return c;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c   = '0;
    c.w = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-cycle controls, first entry = cycle after s is sampled,
  // last entry = idle again. Trace length equals the instruction latency.
  task automatic build(input logic [2:0] opc, input logic [1:0] op);
    ctl_t c;
    logic alu, movi, movr;
    exp_q.delete();
    alu  = (opc == 3'b101);
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    c = '0;
    c.illegal = !(alu || movi || movr);
    exp_q.push_back(c);
    if (movi) begin
      c = '0; c.nsel = 3'b100; c.vsel = 2'b10; c.write = 1'b1;
      exp_q.push_back(c);
    end else if (alu || movr) begin
      if (alu && op != 2'b11) begin
        c = '0; c.nsel = 3'b100; c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = '0; c.nsel = 3'b001; c.loadb = 1'b1;
      exp_q.push_back(c);
      c = '0;
      c.asel  = movr || (alu && op == 2'b11);
      c.loads = alu;
      c.loadc = !(alu && op == 2'b01);
      exp_q.push_back(c);
      if (c.loadc) begin
        c = '0; c.nsel = 3'b010; c.write = 1'b1;
        exp_q.push_back(c);
      end
    end
    exp_q.push_back(idle_ctl());
  endtask

  // Launch one instruction from WAIT. toggle: randomize s while busy.
  // keep_s: s level left on return to WAIT. abort_at: trace index at which
  // reset is applied instead of the normal edge (-1 = never).
  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] op,
                           input bit toggle, input bit keep_s, input int abort_at);
    ctl_t o;
    int   writes;
    int   exp_writes;
    build(opc, op);
    bus.opcode = opc;
    bus.op     = op;
    bus.s      = 1'b1;
    writes     = 0;
    exp_writes = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        reset  = 1'b1;
        bus.s  = 1'b0;
        step();
        reset  = 1'b0;
        check({name, "_abort_idle"}, 32'(observe()), 32'(idle_ctl()));
        check({name, "_abort_writes"}, 32'(writes), 32'(exp_writes));
        return;
      end
      step();
      o = observe();
      check($sformatf("%s_cyc%0d", name, i), 32'(o), 32'(exp_q[i]));
      if (o.write === 1'b1) writes++;
      if (exp_q[i].write) exp_writes++;
      if (i < exp_q.size() - 1) bus.s = toggle ? 1'($urandom) : 1'b0;
      else                      bus.s = keep_s;
    end
    check({name, "_writes"}, 32'(writes), 32'(exp_writes));
  endtask

  initial begin
    logic [2:0] opc;
    logic [1:0] op;
    int         sel;
    int         abort_at;
    bit         keep;

    n_total    = 0;
    n_pass     = 0;
    reset      = 1'b1;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;

    // Reset state, with s high to show reset wins
    bus.s = 1'b1;
    step();
    step();
    check("reset_state", 32'(observe()), 32'(idle_ctl()));
    reset = 1'b0;
    bus.s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_hold", 32'(observe()), 32'(idle_ctl()));
    end

    // Directed instruction set
    run_instr("mov_imm", 3'b110, 2'b10, 1'b0, 1'b0, -1);
    run_instr("add",     3'b101, 2'b00, 1'b0, 1'b0, -1);
    run_instr("cmp",     3'b101, 2'b01, 1'b0, 1'b0, -1);
    run_instr("and",     3'b101, 2'b10, 1'b0, 1'b0, -1);
    run_instr("mvn",     3'b101, 2'b11, 1'b0, 1'b0, -1);
    run_instr("mov_reg", 3'b110, 2'b00, 1'b0, 1'b0, -1);

    // Boundaries
    run_instr("add_s_toggle", 3'b101, 2'b00, 1'b1, 1'b0, -1);
    run_instr("add_rst_getb", 3'b101, 2'b00, 1'b0, 1'b0, 3);
    run_instr("illegal_000",  3'b000, 2'b00, 1'b0, 1'b0, -1);
    run_instr("illegal_mov1", 3'b110, 2'b01, 1'b0, 1'b0, -1);
    run_instr("b2b_movi",     3'b110, 2'b10, 1'b0, 1'b1, -1);
    run_instr("b2b_add",      3'b101, 2'b00, 1'b0, 1'b1, -1);
    run_instr("b2b_cmp",      3'b101, 2'b01, 1'b0, 1'b0, -1);

    // Randomized instruction stream with occasional mid-instruction reset
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel < 2)       opc = 3'b101;
      else if (sel == 2) opc = 3'b110;
      else               opc = 3'($urandom);
      op   = 2'($urandom);
      keep = 1'($urandom);
      build(opc, op);
      abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, exp_q.size() - 1) : -1;
      run_instr($sformatf("rnd%0d", n), opc, op, 1'($urandom), keep, abort_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
